// File: rtl/matrix_cfg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : matrix_cfg_bridge
// Description : AXI4-Lite slave that programs and reads the coupling-matrix
//               weights and holds the ising_rstn control register.
//               Optional macro BRIDGE_SLVERR_EN: SLVERR on out-of-range access.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_cfg_bridge #(
    parameter int N      = 8,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 axi_rstn,
    input  logic [31:0]          s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [31:0]          s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    output logic                 ising_rstn,
    output logic                 wready,
    output logic                 wr_match,
    output logic [$clog2(N)-1:0] s_addr,
    output logic [$clog2(N)-1:0] d_addr,
    output logic                 s_gt_d,
    output logic [31:0]          wdata,
    input  logic [31:0]          rdata
);

    localparam int LOG2N = $clog2(N);
    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_WR_ISSUE = 3'd1;
    localparam logic [2:0] c_WR_RESP  = 3'd2;
    localparam logic [2:0] c_RD_WAIT  = 3'd3;
    localparam logic [2:0] c_RD_RESP  = 3'd4;

    localparam logic [1:0] c_TGT_MAT  = 2'd0;
    localparam logic [1:0] c_TGT_CTRL = 2'd1;
    localparam logic [1:0] c_TGT_OOR  = 2'd2;

    localparam logic [1:0]       c_RESP_OKAY = 2'b00;
    localparam logic [CNT_W-1:0] c_CNT_INIT  = CNT_W'(RD_LAT - 1);
`ifdef BRIDGE_SLVERR_EN
    localparam logic [1:0]  c_OOR_RESP  = 2'b10;
    localparam logic [31:0] c_OOR_RDATA = 32'hDEAD_BEEF;
`else
    localparam logic [1:0]  c_OOR_RESP  = 2'b00;
    localparam logic [31:0] c_OOR_RDATA = 32'h0000_0000;
`endif

    // Word index layout: {out-of-range bits, ctrl bit, s, d}
    function automatic logic [1:0] f_target(input logic [29:0] word);
        logic [1:0] tgt;
        if (word[29:2*LOG2N+1] != '0)
            tgt = c_TGT_OOR;
        else if (word[2*LOG2N])
            tgt = (word[2*LOG2N-1:0] == '0) ? c_TGT_CTRL : c_TGT_OOR;
        else
            tgt = c_TGT_MAT;
        return tgt;
    endfunction

    logic [2:0]       r_state;
    logic             r_aw_held, r_w_held, r_rd_ctrl;
    logic [29:0]      r_awaddr;
    logic [1:0]       r_wr_tgt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bvalid, r_rvalid, r_ising_rstn;
    logic [1:0]       r_bresp, r_rresp;
    logic [31:0]      r_rdata, r_wdata;
    logic             r_mat_wready, r_wr_match, r_s_gt_d;
    logic [LOG2N-1:0] r_s_addr, r_d_addr;

    logic [29:0]      w_wr_word, w_rd_word;
    logic [LOG2N-1:0] w_wr_s, w_wr_d, w_rd_s, w_rd_d;
    logic [1:0]       w_wr_tgt, w_rd_tgt;
    logic             w_idle, w_aw_hs, w_w_hs, w_ar_hs, w_wr_go;
    logic             w_unused;

    assign w_idle    = (r_state == c_IDLE);
    assign w_wr_word = r_aw_held ? r_awaddr : s_axi_awaddr[31:2];
    assign w_rd_word = s_axi_araddr[31:2];
    assign w_wr_s    = w_wr_word[2*LOG2N-1:LOG2N];
    assign w_wr_d    = w_wr_word[LOG2N-1:0];
    assign w_rd_s    = w_rd_word[2*LOG2N-1:LOG2N];
    assign w_rd_d    = w_rd_word[LOG2N-1:0];
    assign w_wr_tgt  = f_target(w_wr_word);
    assign w_rd_tgt  = f_target(w_rd_word);
    assign w_unused  = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // A pending or same-cycle write beat blocks AR so the write always wins
    assign s_axi_awready = w_idle & ~r_aw_held;
    assign s_axi_wready  = w_idle & ~r_w_held;
    assign s_axi_arready = w_idle & ~r_aw_held & ~r_w_held & ~s_axi_awvalid & ~s_axi_wvalid;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;
    assign w_ar_hs = s_axi_arvalid & s_axi_arready;
    assign w_wr_go = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_state      <= c_IDLE;
            r_aw_held    <= 1'b0;
            r_w_held     <= 1'b0;
            r_rd_ctrl    <= 1'b0;
            r_awaddr     <= '0;
            r_wr_tgt     <= c_TGT_MAT;
            r_cnt        <= '0;
            r_bvalid     <= 1'b0;
            r_rvalid     <= 1'b0;
            r_ising_rstn <= 1'b0;
            r_bresp      <= c_RESP_OKAY;
            r_rresp      <= c_RESP_OKAY;
            r_rdata      <= '0;
            r_wdata      <= '0;
            r_mat_wready <= 1'b0;
            r_wr_match   <= 1'b0;
            r_s_gt_d     <= 1'b0;
            r_s_addr     <= '0;
            r_d_addr     <= '0;
        end else begin
            r_mat_wready <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_axi_awaddr[31:2];
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_axi_wdata;
                    end
                    if (w_wr_go) begin
                        r_state  <= c_WR_ISSUE;
                        r_wr_tgt <= w_wr_tgt;
                        if (w_wr_tgt == c_TGT_MAT) begin
                            r_mat_wready <= 1'b1;
                            r_wr_match   <= 1'b1;
                            r_s_addr     <= w_wr_s;
                            r_d_addr     <= w_wr_d;
                            r_s_gt_d     <= (w_wr_s > w_wr_d);
                        end
                    end else if (w_ar_hs) begin
                        r_cnt     <= c_CNT_INIT;
                        r_rd_ctrl <= (w_rd_tgt == c_TGT_CTRL);
                        if (w_rd_tgt == c_TGT_OOR) begin
                            r_rdata  <= c_OOR_RDATA;
                            r_rresp  <= c_OOR_RESP;
                            r_rvalid <= 1'b1;
                            r_state  <= c_RD_RESP;
                        end else begin
                            r_state <= c_RD_WAIT;
                            if (w_rd_tgt == c_TGT_MAT) begin
                                r_wr_match <= 1'b1;
                                r_s_addr   <= w_rd_s;
                                r_d_addr   <= w_rd_d;
                                r_s_gt_d   <= (w_rd_s > w_rd_d);
                            end
                        end
                    end
                end
                c_WR_ISSUE: begin
                    r_wr_match <= 1'b0;
                    if (r_wr_tgt == c_TGT_CTRL)
                        r_ising_rstn <= r_wdata[0];
                    r_bresp  <= (r_wr_tgt == c_TGT_OOR) ? c_OOR_RESP : c_RESP_OKAY;
                    r_bvalid <= 1'b1;
                    r_state  <= c_WR_RESP;
                end
                c_WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                c_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_wr_match <= 1'b0;
                        r_rdata    <= r_rd_ctrl ? {31'b0, r_ising_rstn} : rdata;
                        r_rresp    <= c_RESP_OKAY;
                        r_rvalid   <= 1'b1;
                        r_state    <= c_RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_RD_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rdata  = r_rdata;
    assign ising_rstn   = r_ising_rstn;
    assign wready       = r_mat_wready;
    assign wr_match     = r_wr_match;
    assign s_addr       = r_s_addr;
    assign d_addr       = r_d_addr;
    assign s_gt_d       = r_s_gt_d;
    assign wdata        = r_wdata;

endmodule
`default_nettype wire
